// File: rtl/mux4_to_1.sv
// mux4_to_1: registered 4-to-1 selector, index {s1,s0}; define MUX4_TO_1_SEL_OUT_EN to expose registered select sel_q
module mux4_to_1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic             s0,
  input  logic             s1,
`ifdef MUX4_TO_1_SEL_OUT_EN
  output logic [1:0]       sel_q,
`endif
  output logic [WIDTH-1:0] y
);
  logic [WIDTH-1:0] sel_d;
  always_comb sel_d = s1 ? (s0 ? d3 : d2) : (s0 ? d1 : d0);
  always_ff @(posedge clk) y <= rst ? '0 : sel_d;
`ifdef MUX4_TO_1_SEL_OUT_EN
  always_ff @(posedge clk) sel_q <= rst ? 2'b00 : {s1, s0};
`endif
endmodule

// File: tb/tb_mux4_to_1.sv
module tb_mux4_to_1;
  logic clk = 1'b0, rst = 1'b0, s0 = 1'b0, s1 = 1'b0;
  logic a0 = 1'b0, a1 = 1'b0, a2 = 1'b0, a3 = 1'b0, y1;
  logic [7:0] b0 = '0, b1 = '0, b2 = '0, b3 = '0, y8;
`ifdef MUX4_TO_1_SEL_OUT_EN
  logic [1:0] q1, q8;
`endif
  always #5 clk = ~clk;
  mux4_to_1 #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .d0(a0), .d1(a1), .d2(a2), .d3(a3), .s0(s0), .s1(s1),
`ifdef MUX4_TO_1_SEL_OUT_EN
    .sel_q(q1),
`endif
    .y(y1)
  );
  mux4_to_1 #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .d0(b0), .d1(b1), .d2(b2), .d3(b3), .s0(s0), .s1(s1),
`ifdef MUX4_TO_1_SEL_OUT_EN
    .sel_q(q8),
`endif
    .y(y8)
  );
  typedef struct {
    string      tag;
    logic       e1;
    logic [7:0] e8;
    logic [1:0] es;
  } exp_t;
  typedef struct {
    logic       r;
    logic [1:0] sel;
    logic [7:0] e8;
  } vec_t;
  exp_t sb[$];
  vec_t tbl[5];
  int errs = 0, checks = 0;
  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  // Expected values are captured at drive time, then compared after the next rising edge.
  task automatic cyc(input string tag, input bit use_tbl, input logic [7:0] e8t);
    exp_t e;
    logic v[4];
    logic [7:0] w[4];
    v = '{a0, a1, a2, a3};
    w = '{b0, b1, b2, b3};
    e.tag = tag;
    e.e1 = rst ? 1'b0 : v[{s1, s0}];
    e.e8 = use_tbl ? e8t : (rst ? 8'h00 : w[{s1, s0}]);
    e.es = rst ? 2'b00 : {s1, s0};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".y1"}, {7'b0, y1}, {7'b0, e.e1});
    chk({e.tag, ".y8"}, y8, e.e8);
`ifdef MUX4_TO_1_SEL_OUT_EN
    chk({e.tag, ".q1"}, {6'b0, q1}, {6'b0, e.es});
    chk({e.tag, ".q8"}, {6'b0, q8}, {6'b0, e.es});
`endif
  endtask
  initial begin
    tbl[0] = '{1'b0, 2'd1, 8'h3C};
    tbl[1] = '{1'b1, 2'd1, 8'h00};
    tbl[2] = '{1'b0, 2'd2, 8'hFF};
    tbl[3] = '{1'b0, 2'd0, 8'hA5};
    tbl[4] = '{1'b0, 2'd3, 8'h00};
    {a0, a1, a2, a3} = 4'b1111;
    {b0, b1, b2, b3} = {4{8'h01}};
    {s1, s0} = 2'd3;
    rst = 1'b1;
    cyc("rst0", 1'b0, 8'h00);
    cyc("rst1", 1'b0, 8'h00);
    rst = 1'b0;
    cyc("rel", 1'b1, 8'h01);
    for (int i = 0; i < 64; i++) begin
      logic [5:0] iv;
      iv = 6'(i);
      {a0, a1, a2, a3, s1, s0} = iv;
      {b0, b1, b2, b3} = {~{8{iv[5]}}, 8'h11, {8{iv[3]}} ^ 8'h5A, 8'h80 | 8'(i)};
      cyc("exh", 1'b0, 8'h00);
    end
    {s1, s0} = 2'd2;
    a2 = 1'b0;
    b2 = 8'h00;
    for (int i = 0; i < 4; i++) begin
      {a0, a1, a3} = {3{i[0]}};
      {b0, b1, b3} = {3{8'(i) ^ 8'hFF}};
      cyc("iso", 1'b0, 8'h00);
    end
    a2 = 1'b1;
    b2 = 8'hC3;
    cyc("iso_flip", 1'b0, 8'h00);
    {a0, a1, a2, a3} = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      {s1, s0} = 2'(i);
      cyc("b2b", 1'b0, 8'h00);
    end
    {b0, b1, b2, b3} = {8'hA5, 8'h3C, 8'hFF, 8'h00};
    for (int i = 0; i < 5; i++) begin
      rst = tbl[i].r;
      {s1, s0} = tbl[i].sel;
      cyc("w8", 1'b1, tbl[i].e8);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
